// File: rtl/imem_loader_if.sv
// Byte stream from the UART receiver plus the instruction-memory write port,
// bundled so the loader and its neighbours share one set of names.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian word image from the UART,
// writes it into instruction memory and keeps the core stalled until it is complete.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERROR} state_t;

    state_t        state;
    logic [7:0]    count_lo;
    logic [15:0]   count;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   len_rx;
    logic          timed_out;

    assign len_rx    = {bus.rx_data, count_lo};
    assign timed_out = (TIMEOUT_CYCLES != 0) && !bus.rx_valid
                       && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count_lo       <= '0;
            count          <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            idle_cnt       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_req) begin
                        state        <= LEN_LO;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        idle_cnt     <= '0;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                LEN_LO, LEN_HI, DATA: begin
                    // A stalled stream leaves the core frozen; any partial word is dropped.
                    if (timed_out) begin
                        state <= ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!bus.rx_valid) begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end else begin
                        idle_cnt <= '0;
                        if (state == LEN_LO) begin
                            count_lo <= bus.rx_data;
                            state    <= LEN_HI;
                        end else if (state == LEN_HI) begin
                            count <= len_rx;
                            if (len_rx == 16'd0) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                cpu_hold <= 1'b0;
                            end else if (32'(len_rx) > MAX_WORDS) begin
                                state <= ERROR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= ADDR_WIDTH'(BASE_ADDR)
                                                  + ADDR_WIDTH'({words_loaded, 2'b00});
                                bus.imem_wdata <= DATA_WIDTH'({bus.rx_data, word_buf});
                                words_loaded   <= words_loaded + 16'd1;
                                if (words_loaded + 16'd1 == count) begin
                                    state <= FLUSH;
                                end
                            end else begin
                                word_buf[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images are checked against a
// byte-list reference model of the load protocol.
module tb_imem_loader;

    localparam int unsigned BASE = 32'h0100;
    localparam int unsigned MAXW = 256;
    localparam int unsigned TO   = 100;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    imem_loader #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] byte_q[$];
    wr_t        exp_q[$];
    wr_t        seen_q[$];
    logic       exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we) seen_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic startLoad(input string tag);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        seen_q.delete();
        checkOutput({tag, ":start_busy"}, busy, 1);
        checkOutput({tag, ":start_hold"}, cpu_hold, 1);
        checkOutput({tag, ":start_err"}, error, 0);
        checkOutput({tag, ":start_words"}, words_loaded, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ":we"}, bus.imem_we, 0);
        checkOutput({tag, ":addr"}, bus.imem_addr, 0);
        checkOutput({tag, ":wdata"}, bus.imem_wdata, 0);
        checkOutput({tag, ":hold"}, cpu_hold, 0);
        checkOutput({tag, ":busy"}, busy, 0);
        checkOutput({tag, ":done"}, done, 0);
        checkOutput({tag, ":error"}, error, 0);
        checkOutput({tag, ":words"}, words_loaded, 0);
    endtask

    // Length header followed by cnt random words; oversize counts carry no payload.
    task automatic makeLoad(input int unsigned cnt);
        byte_q.delete();
        byte_q.push_back(cnt[7:0]);
        byte_q.push_back(cnt[15:8]);
        if (cnt <= MAXW)
            for (int unsigned i = 0; i < 4 * cnt; i++) byte_q.push_back(8'($urandom));
    endtask

    function automatic void buildModel();
        int unsigned cnt;
        exp_q.delete();
        cnt     = {16'd0, byte_q[1], byte_q[0]};
        exp_err = (cnt > MAXW);
        if (!exp_err) begin
            for (int unsigned i = 0; i < cnt; i++) begin
                wr_t w;
                w.addr = 16'((BASE + 4 * i) % 65536);
                w.data = {byte_q[2 + 4*i + 3], byte_q[2 + 4*i + 2],
                          byte_q[2 + 4*i + 1], byte_q[2 + 4*i]};
                exp_q.push_back(w);
            end
        end
    endfunction

    task automatic finishLoad(input string tag);
        buildModel();
        for (int i = 0; i < 20 && !(done || error); i++) tick();
        checkOutput({tag, ":ended"}, done | error, 1);
        checkOutput({tag, ":done"}, done, !exp_err);
        checkOutput({tag, ":error"}, error, exp_err);
        checkOutput({tag, ":hold"}, cpu_hold, exp_err);
        checkOutput({tag, ":busy"}, busy, 0);
        checkOutput({tag, ":words"}, words_loaded, exp_q.size());
        checkOutput({tag, ":nwrites"}, seen_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < seen_q.size()) begin
                checkOutput($sformatf("%s:addr%0d", tag, i), seen_q[i].addr, exp_q[i].addr);
                checkOutput($sformatf("%s:data%0d", tag, i), seen_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic runLoad(input string tag, input int max_gap);
        startLoad(tag);
        foreach (byte_q[i]) applyStimulus(byte_q[i], $urandom_range(max_gap, 0));
        finishLoad(tag);
    endtask

    initial begin
        rst          = 1'b1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) tick();
        checkResetState("reset");
        rst = 1'b0;
        tick();

        // Reference image from the bring-up notes; final write then two cycles to release.
        byte_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        startLoad("normal");
        foreach (byte_q[i]) applyStimulus(byte_q[i], 0);
        checkOutput("normal:flush_we", bus.imem_we, 1);
        checkOutput("normal:flush_hold", cpu_hold, 1);
        checkOutput("normal:flush_busy", busy, 1);
        tick();
        checkOutput("normal:release_hold", cpu_hold, 0);
        checkOutput("normal:release_done", done, 1);
        finishLoad("normal");
        checkOutput("normal:word0", seen_q.size() > 0 ? seen_q[0].data : 32'hx, 32'h00500093);

        makeLoad(3);
        runLoad("b2b", 0);

        makeLoad(0);
        runLoad("len0", 0);

        makeLoad(256);
        runLoad("len256", 1);

        makeLoad(257);
        runLoad("len257", 0);

        byte_q = '{8'h01, 8'h00};
        startLoad("tmo");
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        repeat (TO - 1) tick();
        checkOutput("tmo:err_early", error, 0);
        tick();
        checkOutput("tmo:err_at_limit", error, 1);
        checkOutput("tmo:hold", cpu_hold, 1);
        checkOutput("tmo:busy", busy, 0);
        checkOutput("tmo:nwrites", seen_q.size(), 0);
        makeLoad(2);
        runLoad("tmo_reload", 2);

        makeLoad(3);
        startLoad("rstmid");
        for (int i = 0; i < 7; i++) applyStimulus(byte_q[i], 0);
        checkOutput("rstmid:words_before", words_loaded, 1);
        rst = 1'b1;
        tick();
        checkResetState("rstmid");
        rst = 1'b0;
        seen_q.delete();
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 0);
        repeat (2) tick();
        checkOutput("rstmid:no_write", seen_q.size(), 0);
        checkOutput("rstmid:idle_busy", busy, 0);

        // Reset landing on the fourth byte of a word must cancel that write.
        makeLoad(2);
        startLoad("rst4th");
        for (int i = 0; i < 5; i++) applyStimulus(byte_q[i], 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = byte_q[5];
        rst          = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        rst          = 1'b0;
        tick();
        checkOutput("rst4th:no_write", seen_q.size(), 0);
        checkOutput("rst4th:words", words_loaded, 0);

        makeLoad(2);
        startLoad("reqdata");
        for (int i = 0; i < 6; i++) applyStimulus(byte_q[i], 0);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checkOutput("reqdata:words_kept", words_loaded, 1);
        checkOutput("reqdata:busy", busy, 1);
        for (int i = 6; i < byte_q.size(); i++) applyStimulus(byte_q[i], 0);
        finishLoad("reqdata");

        seen_q.delete();
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 0);
        tick();
        checkOutput("rxdone:no_write", seen_q.size(), 0);
        checkOutput("rxdone:done", done, 1);
        checkOutput("rxdone:words", words_loaded, 2);

        // 0x05 arriving with load_req would make 05 01 an oversize length if it were consumed.
        makeLoad(1);
        load_req     = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h05;
        tick();
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        seen_q.delete();
        checkOutput("reqrx:busy", busy, 1);
        foreach (byte_q[i]) applyStimulus(byte_q[i], 0);
        finishLoad("reqrx");

        for (int n = 0; n < 6; n++) begin
            makeLoad($urandom_range(6, 1));
            runLoad($sformatf("rand%0d", n), 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot/program-load controller for the pipelined core's instruction memory.
- Receives a framed byte stream from the UART receiver and assembles little-endian 32-bit words.
- Sequences one-cycle word writes into instruction memory while holding the core stalled, then releases the core and reports status.
- Sits between the UART RX path, the imem write port and the core's hold/stall input.

Parameters:
- ADDR_WIDTH, 16, imem byte-address width.
- DATA_WIDTH, 32, imem word width; fixed at 4 bytes per word.
- BASE_ADDR, 0, byte address of the first loaded word.
- MAX_WORDS, 256, largest accepted word count.
- TIMEOUT_CYCLES, 50000000, idle cycles between bytes before an abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_req  in  1  one-cycle pulse that starts a load
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- rx_data  in  8  received byte
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word-aligned byte address
- imem_wdata  out  DATA_WIDTH  assembled word
- cpu_hold  out  1  stalls the core (PC and pipeline registers frozen) while high
- busy  out  1  load in progress
- done  out  1  sticky: last load completed
- error  out  1  sticky: last load aborted
- words_loaded  out  16  words written in the current or last load

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, including imem_addr and imem_wdata.
  - The timeout counter and byte index are cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERROR.
- All outputs are registered.
- IDLE/DONE/ERROR:
  - rx_valid is ignored.
  - load_req moves to LEN_LO on the next cycle.
  - On that transition: clear done, error, words_loaded and the byte index; set cpu_hold=1 and busy=1.
- LEN_LO, on rx_valid:
  - Latch count[7:0].
  - Go to LEN_HI.
- LEN_HI, on rx_valid:
  - Form count = {rx_data, count[7:0]}.
  - If count==0: go to DONE.
  - Else if count>MAX_WORDS: go to ERROR.
  - Else: go to DATA.
- DATA, on rx_valid:
  - Shift the byte into lane byte_idx (byte 0 = bits 7:0); byte_idx is 2 bits.
  - On the 4th byte (byte_idx==3):
    - Next cycle: imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*words_loaded and imem_wdata = the full word.
    - words_loaded increments in that same cycle.
    - byte_idx wraps to 0.
  - Bytes may arrive on every cycle, including the cycle imem_we is high; no byte is dropped.
  - If the word is the count-th word, go to FLUSH instead of staying in DATA.
- FLUSH:
  - Lasts one cycle, which is the cycle imem_we is high for the final word; cpu_hold stays 1.
  - Next state is DONE.
- DONE:
  - cpu_hold=0, busy=0, done=1.
  - The core resumes at least one cycle after the last write.
- Timeout (LEN_LO, LEN_HI, DATA only):
  - The counter clears on entry to LEN_LO and on every accepted byte.
  - If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES consecutive cycles pass without rx_valid: go to ERROR.
  - A partial word is discarded and no imem_we is issued for it.
- ERROR:
  - error=1, busy=0, cpu_hold=1.
  - The core stays frozen on a partially written image until a new load_req or rst.
- load_req while busy: ignored.
- imem_addr arithmetic:
  - Computed modulo 2^ADDR_WIDTH.
  - Bits 1:0 are always 0 when BASE_ADDR is word-aligned.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst mid-load:
  - Return to IDLE next cycle with all outputs 0, which releases cpu_hold.
  - Any pending imem_we is suppressed.
- rx_valid and load_req in the same cycle in IDLE: start the load; the byte is not used as LEN_LO.

Test Plan:
- Normal load:
  - Stimulus: load_req, then bytes 02 00 93 00 50 00 13 01 A0 00.
  - Response: imem_we pulses at addr 0x0000 data 0x00500093 and at addr 0x0004 data 0x00A00113.
  - Then FLUSH, then done=1, words_loaded=2, cpu_hold falls 2 cycles after the final byte, error=0.
- Back-to-back bytes:
  - Stimulus: 3 words with rx_valid high every cycle, BASE_ADDR=0x0100.
  - Response: writes to 0x0100, 0x0104 and 0x0108, exactly 3 imem_we pulses, no lost bytes.
- Length boundaries:
  - count=0 (00 00): done=1, no imem_we, words_loaded=0.
  - count=256: accepted, 256 writes, last at 0x03FC.
  - count=257 (01 01): error=1, cpu_hold=1, no writes.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100, count=1, send 2 data bytes, then silence.
  - Response: error=1 exactly 100 cycles after the 2nd byte, no imem_we.
  - Then load_req: error clears, and a fresh load succeeds.
- Reset mid-load:
  - Stimulus: assert rst after 5 data bytes.
  - Response: next cycle all outputs are 0 and state is IDLE.
  - A subsequent rx_valid without load_req produces no write.
- Ignored events:
  - load_req during DATA: no restart, words_loaded unaffected.
  - rx_valid in DONE: no imem_we.
  - load_req together with rx_valid=0x05 in IDLE: the byte is ignored, so the next two bytes form the length.
